// File: rtl/game_pkg.sv
// Shared game definitions: mover state encoding, step direction codes and
// the playfield limits that the VGA sprite drawer also uses.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_ARRIVE = 2'd3
  } state_t;

  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_NX = 2'd1;
  localparam logic [1:0] DIR_PY = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  localparam int GRID_X_MAX = 159;
  localparam int GRID_Y_MAX = 119;

endpackage

// File: rtl/axis_stepper.sv
// One-axis unit stepper: proposes the next coordinate one cell toward the
// target when enabled, and reports arrival and step sign.
module axis_stepper #(
  parameter int W = 8
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] target,
  input  logic         step_en,
  output logic [W-1:0] next_pos,
  output logic         at_target,
  output logic         step_neg
);

  assign at_target = (pos == target);
  assign step_neg  = (target < pos);

  always_comb begin
    next_pos = pos;
    if (step_en && !at_target)
      next_pos = step_neg ? pos - W'(1) : pos + W'(1);
  end

endmodule

// File: rtl/character_mover.sv
// Walks the player sprite one grid cell per rate-divider tick toward a
// latched target, X first then Y, and pulses done on arrival.
module character_mover
  import game_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int X_MAX   = GRID_X_MAX,
  parameter int Y_MAX   = GRID_Y_MAX,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           tick,
  input  logic           go,
  input  logic           abort,
  input  logic [X_W-1:0] target_x,
  input  logic [Y_W-1:0] target_y,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     dir,
  output logic [1:0]     frame,
  output logic           busy,
  output logic           done
);

  localparam logic [X_W-1:0] XLIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YLIM = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] SX   = X_W'(START_X);
  localparam logic [Y_W-1:0] SY   = Y_W'(START_Y);

  state_t         state;
  logic [X_W-1:0] tx, nx;
  logic [Y_W-1:0] ty, ny;
  logic           x_at, x_neg, y_at, y_neg;

  axis_stepper #(.W(X_W)) u_x (
    .pos(pos_x), .target(tx), .step_en(tick),
    .next_pos(nx), .at_target(x_at), .step_neg(x_neg)
  );

  axis_stepper #(.W(Y_W)) u_y (
    .pos(pos_y), .target(ty), .step_en(tick),
    .next_pos(ny), .at_target(y_at), .step_neg(y_neg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      pos_x <= SX;
      pos_y <= SY;
      tx    <= SX;
      ty    <= SY;
      dir   <= DIR_PX;
      frame <= 2'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Clamp at latch time so the steppers can never walk off-grid.
          if (go) begin
            tx    <= (target_x > XLIM) ? XLIM : target_x;
            ty    <= (target_y > YLIM) ? YLIM : target_y;
            state <= ST_MOVE_X;
            busy  <= 1'b1;
          end
        end
        ST_MOVE_X: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            frame <= 2'd0;
          end else if (x_at) begin
            state <= ST_MOVE_Y;
          end else if (tick) begin
            pos_x <= nx;
            dir   <= x_neg ? DIR_NX : DIR_PX;
            frame <= frame + 2'd1;
          end
        end
        ST_MOVE_Y: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            frame <= 2'd0;
          end else if (y_at) begin
            state <= ST_ARRIVE;
            done  <= 1'b1;
          end else if (tick) begin
            pos_y <= ny;
            dir   <= y_neg ? DIR_NY : DIR_PY;
            frame <= frame + 2'd1;
          end
        end
        ST_ARRIVE: begin
          // Abort here lands in the same place, so it needs no branch.
          state <= ST_IDLE;
          busy  <= 1'b0;
          frame <= 2'd0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_character_mover.sv
// Directed bench for character_mover: a table of moves with hand-computed
// endpoints plus hand-written sequences for timing, reset and abort cases.
module tb_character_mover;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       go    = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] target_x = '0;
  logic [6:0] target_y = '0;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [1:0] dir, frame;
  logic       busy, done;

  character_mover dut (
    .clock(clock), .reset(reset), .tick(tick), .go(go), .abort(abort),
    .target_x(target_x), .target_y(target_y),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .frame(frame),
    .busy(busy), .done(done)
  );

  always #10 clock = ~clock;

  typedef struct {
    int tx, ty;
    int ex, ey, edir, eticks;
  } vec_t;

  vec_t tbl[6];
  int   nchk = 0;
  int   nerr = 0;
  int   qx[$], qy[$], qd[$], qf[$];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Ticks every 4th cycle until busy drops; records every position change.
  task automatic wait_move(output int ticks, output int dones,
                           output int maxx, output int maxy);
    int px, py;
    int fin;
    ticks = 0; dones = 0; maxx = 0; maxy = 0; fin = 0;
    qx.delete(); qy.delete(); qd.delete(); qf.delete();
    px = int'(pos_x); py = int'(pos_y);
    for (int c = 0; c < 3000; c++) begin
      tick = (c % 4 == 3);
      if (tick) ticks++;
      cyc();
      if (done) dones++;
      if (int'(pos_x) > maxx) maxx = int'(pos_x);
      if (int'(pos_y) > maxy) maxy = int'(pos_y);
      if (int'(pos_x) != px || int'(pos_y) != py) begin
        qx.push_back(int'(pos_x)); qy.push_back(int'(pos_y));
        qd.push_back(int'(dir));   qf.push_back(int'(frame));
        px = int'(pos_x); py = int'(pos_y);
      end
      if (!busy) begin
        fin = 1;
        break;
      end
    end
    tick = 1'b0;
    chk("move_terminates", fin, 1);
  endtask

  task automatic run_move(input int tx, input int ty, output int ticks,
                          output int dones, output int maxx, output int maxy);
    target_x = 8'(tx);
    target_y = 7'(ty);
    go = 1'b1;
    tick = 1'b0;
    cyc();
    go = 1'b0;
    wait_move(ticks, dones, maxx, maxy);
  endtask

  initial begin
    int ticks, dones, maxx, maxy, cnt, found;
    int hx[5] = '{1, 2, 3, 3, 3};
    int hy[5] = '{0, 0, 0, 1, 2};
    int hd[5] = '{0, 0, 0, 2, 2};
    int hf[5] = '{1, 2, 3, 0, 1};

    tbl[0] = '{tx: 0,   ty: 0,   ex: 0,   ey: 0,   edir: 3, eticks: 5};
    tbl[1] = '{tx: 5,   ty: 5,   ex: 5,   ey: 5,   edir: 2, eticks: 10};
    tbl[2] = '{tx: 200, ty: 127, ex: 159, ey: 119, edir: 2, eticks: 268};
    tbl[3] = '{tx: 150, ty: 119, ex: 150, ey: 119, edir: 1, eticks: 9};
    tbl[4] = '{tx: 150, ty: 119, ex: 150, ey: 119, edir: 1, eticks: 0};
    tbl[5] = '{tx: 10,  ty: 100, ex: 10,  ey: 100, edir: 3, eticks: 159};

    // Reset state
    cyc(); cyc();
    chk("rst_pos_x", int'(pos_x), 0);
    chk("rst_pos_y", int'(pos_y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_frame", int'(frame), 0);
    reset = 1'b0;

    // Abort and tick in IDLE do nothing
    abort = 1'b1; tick = 1'b1;
    cyc();
    abort = 1'b0; tick = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_pos_x", int'(pos_x), 0);

    // (0,0) -> (3,2) with per-step trace
    run_move(3, 2, ticks, dones, maxx, maxy);
    chk("h32_ticks", ticks, 5);
    chk("h32_dones", dones, 1);
    chk("h32_steps", qx.size(), 5);
    for (int i = 0; i < 5 && i < qx.size(); i++) begin
      chk($sformatf("h32_step%0d_x", i), qx[i], hx[i]);
      chk($sformatf("h32_step%0d_y", i), qy[i], hy[i]);
      chk($sformatf("h32_step%0d_dir", i), qd[i], hd[i]);
      chk($sformatf("h32_step%0d_frame", i), qf[i], hf[i]);
    end
    chk("h32_end_frame", int'(frame), 0);
    chk("h32_end_busy", int'(busy), 0);

    // Table of moves, each starting where the previous one ended
    for (int v = 0; v < 6; v++) begin
      run_move(tbl[v].tx, tbl[v].ty, ticks, dones, maxx, maxy);
      chk($sformatf("v%0d_pos_x", v), int'(pos_x), tbl[v].ex);
      chk($sformatf("v%0d_pos_y", v), int'(pos_y), tbl[v].ey);
      chk($sformatf("v%0d_dir", v), int'(dir), tbl[v].edir);
      chk($sformatf("v%0d_ticks", v), ticks, tbl[v].eticks);
      chk($sformatf("v%0d_dones", v), dones, 1);
      chk($sformatf("v%0d_frame", v), int'(frame), 0);
      chk($sformatf("v%0d_x_in_range", v), int'(maxx <= 159), 1);
      chk($sformatf("v%0d_y_in_range", v), int'(maxy <= 119), 1);
    end

    // Zero-length move timing from (10,100)
    target_x = 8'd10; target_y = 7'd100; go = 1'b1;
    cyc();
    go = 1'b0;
    chk("zl_c1_busy", int'(busy), 1);
    chk("zl_c1_done", int'(done), 0);
    cyc();
    chk("zl_c2_done", int'(done), 0);
    cyc();
    chk("zl_c3_done", int'(done), 1);
    chk("zl_c3_busy", int'(busy), 1);
    cyc();
    chk("zl_c4_done", int'(done), 0);
    chk("zl_c4_busy", int'(busy), 0);
    chk("zl_pos_x", int'(pos_x), 10);
    chk("zl_pos_y", int'(pos_y), 100);

    // go with a same-cycle tick, then a second go/target while busy
    target_x = 8'd12; target_y = 7'd100; go = 1'b1; tick = 1'b1;
    cyc();
    go = 1'b0; tick = 1'b0;
    chk("gt_no_step", int'(pos_x), 10);
    target_x = 8'd50; target_y = 7'd50; go = 1'b1;
    cyc();
    go = 1'b0;
    chk("gt_busy", int'(busy), 1);
    chk("gt_still", int'(pos_x), 10);
    wait_move(ticks, dones, maxx, maxy);
    chk("gt_pos_x", int'(pos_x), 12);
    chk("gt_pos_y", int'(pos_y), 100);
    chk("gt_ticks", ticks, 2);
    chk("gt_dones", dones, 1);

    // Reset mid-move at (3,0)
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    target_x = 8'd8; target_y = 7'd0; go = 1'b1;
    cyc();
    go = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      tick = (c % 4 == 3);
      cyc();
      tick = 1'b0;
      if (pos_x == 8'd3) begin
        found = 1;
        break;
      end
    end
    chk("mr_reached_3", found, 1);
    reset = 1'b1; tick = 1'b1;
    cyc();
    chk("mr_pos_x", int'(pos_x), 0);
    chk("mr_pos_y", int'(pos_y), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_frame", int'(frame), 0);
    reset = 1'b0;
    cyc();
    tick = 1'b0;
    chk("mr_idle_pos_x", int'(pos_x), 0);
    chk("mr_idle_busy", int'(busy), 0);

    // Abort with a coincident tick at (2,0) en route to (4,0)
    target_x = 8'd4; target_y = 7'd0; go = 1'b1;
    cyc();
    go = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      tick = (c % 4 == 3);
      cyc();
      tick = 1'b0;
      if (pos_x == 8'd2) begin
        found = 1;
        break;
      end
    end
    chk("ab_reached_2", found, 1);
    abort = 1'b1; tick = 1'b1;
    cyc();
    abort = 1'b0; tick = 1'b0;
    chk("ab_pos_x", int'(pos_x), 2);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    chk("ab_frame", int'(frame), 0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick = c[0];
      cyc();
      if (done) cnt++;
    end
    tick = 1'b0;
    chk("ab_no_done", cnt, 0);
    chk("ab_hold_x", int'(pos_x), 2);
    run_move(2, 1, ticks, dones, maxx, maxy);
    chk("ab2_ticks", ticks, 1);
    chk("ab2_pos_x", int'(pos_x), 2);
    chk("ab2_pos_y", int'(pos_y), 1);
    chk("ab2_dir", int'(dir), 2);
    chk("ab2_dones", dones, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/character_mover.md
Name: character_mover

Overview:
- Consumes the one-cycle step-enable pulse from the rate divider and walks the player character one grid cell per pulse toward a requested target cell.
- Movement is Manhattan: all X first, then Y.
- Sits between the game-logic FSM (issues go/target) and the VGA sprite drawer (reads position, direction and animation frame).
- Reports busy, and pulses done when the character arrives.

Parameters:
- X_W, 8, width of X coordinate
- Y_W, 7, width of Y coordinate
- X_MAX, 159, largest legal X cell
- Y_MAX, 119, largest legal Y cell
- START_X, 0, X position after reset
- START_Y, 0, Y position after reset

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle step enable from the rate divider
- go  in  1  start request, sampled only in IDLE
- abort  in  1  stop the current move immediately
- target_x  in  X_W  requested target column
- target_y  in  Y_W  requested target row
- pos_x  out  X_W  current column
- pos_y  out  Y_W  current row
- dir  out  2  last step direction: 0=+X, 1=-X, 2=+Y, 3=-Y
- frame  out  2  walk-animation frame
- busy  out  1  high while a move is in progress
- done  out  1  one-cycle arrival pulse

Behaviour:
- Reset (clock edge with reset=1, any state):
  - pos=START_X/START_Y, dir=0, frame=0, busy=0, done=0, state=IDLE.
  - Latched target is cleared to START.
  - Reset wins over every other input.
- States: IDLE, MOVE_X, MOVE_Y, ARRIVE.
- IDLE:
  - busy=0.
  - On go=1: latch target, clamping tx=min(target_x,X_MAX) and ty=min(target_y,Y_MAX). Next state is MOVE_X; busy=1 from the next cycle.
  - A tick in the same cycle as go is not consumed. The first step occurs on the first tick strictly after the go cycle.
- MOVE_X:
  - Check first, every cycle: if pos_x==tx, go to MOVE_Y without consuming a tick. This takes 1 cycle.
  - Otherwise, on tick: pos_x moves ±1 toward tx, dir=0 or 1, frame increments mod 4.
  - With no tick, hold all outputs.
- MOVE_Y: same as MOVE_X using pos_y/ty and dir 2/3. When pos_y==ty, go to ARRIVE.
- ARRIVE:
  - done=1 for exactly one cycle, busy still 1.
  - Next state is IDLE with busy=0.
  - frame resets to 0 on entry to IDLE.
- Zero-length move (target==pos): IDLE→MOVE_X→MOVE_Y→ARRIVE with no tick needed. done is high 3 cycles after the go edge.
- Move of length L=|dx|+|dy| consumes exactly L ticks. No position ever leaves the range 0..X_MAX / 0..Y_MAX.
- abort=1 in MOVE_X, MOVE_Y or ARRIVE:
  - Next state is IDLE. pos holds its current value, done is not asserted, frame=0.
  - abort outranks tick in the same cycle: no step is taken.
  - abort in IDLE is ignored.
- While busy:
  - go is ignored.
  - target_x/target_y changes are ignored; the latched target is used.
- All outputs are registered. Nothing is combinational from inputs.

Decomposition:
- Shared package (game_pkg) holds:
  - the state encoding localparams;
  - the direction codes DIR_PX/DIR_NX/DIR_PY/DIR_NY;
  - the default grid limits 159/119 shared with the VGA drawer.
- One natural sub-module: axis_stepper, parameterised on width.
  - Inputs: pos, target, step_en.
  - Outputs: next pos, at_target, step sign.
  - Instantiated twice (X and Y).
- The FSM stays in character_mover.

Test Plan:
- Reset → pos=(0,0), busy=0, done=0, dir=0, frame=0. Then reset asserted mid-move at pos (3,0) → pos=(0,0), IDLE on the next cycle.
- go with target (3,2) from (0,0), tick every 4th cycle → pos visits (1,0)(2,0)(3,0)(3,1)(3,2) after exactly 5 ticks. dir sequence 0,0,0,2,2. frame 1,2,3,0,1. One done pulse, then busy=0.
- go with target (0,0) from (0,0), no ticks → done high 3 cycles after go, pos unchanged.
- From (5,5), go to target (200,127) → target clamped to (159,119). Arrives after 154+114=268 ticks; pos never exceeds the limits.
- go and tick in the same cycle, then a second go and target change while busy → the first step occurs only on the next tick; the second go and the new target are ignored and the original target is reached.
- abort coinciding with a tick at pos (2,0) en route to (4,0) → pos stays (2,0), no done, busy=0 the next cycle. A new go to (2,1) then completes after 1 tick.
